// File: rtl/fetch_prefetch_buffer.sv
// Instruction fetch front end: in-order word requests to instruction memory with
// credit-based flow control, a PC-tagged prefetch FIFO, and redirect flush.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, inflight, stale, inflight_nxt;
  logic [31:0]   fetch_pc, rsp_pc, redirect_base;
  logic [CW:0]   credits_used;
  logic          req_fire, pop, push, rsp_stale;
  logic          unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];
  assign redirect_base        = {redirect_pc[31:2], 2'b00};

  // Stale requests still hold credits until their responses drain.
  always_comb begin
    credits_used  = {1'b0, count} + {1'b0, inflight};
    mem_req_valid = !rst && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
    mem_req_addr  = fetch_pc;
    req_fire      = mem_req_valid && mem_req_ready;
    out_valid     = (count != '0);
    pop           = out_valid && out_ready;
    rsp_stale     = (stale != '0);
    push          = mem_rsp_valid && !rsp_stale && !redirect_valid;
    inflight_nxt  = inflight + CW'(req_fire) - CW'(mem_rsp_valid);
    out_instr     = instr_q[rd_ptr];
    out_pc        = pc_q[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      stale    <= '0;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old stream.
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        stale    <= inflight_nxt;
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (mem_rsp_valid && rsp_stale)
          stale <= stale - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_q[wr_ptr] <= mem_rsp_data;
      pc_q[wr_ptr]    <= rsp_pc;
    end
  end
endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Instruction fetch front end directly upstream of the single-cycle RV32 core's decode path.
- Issues in-order word requests to instruction memory over a valid/ready request channel with variable response latency.
- Buffers returned words with their PCs in a small FIFO and presents them to the core over a valid/ready channel.
- Handles control-flow redirects by flushing buffered entries and discarding stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries and also the maximum number of in-flight memory requests (power of 2, min 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
redirect_valid  input  1  core requests fetch restart (jump/branch taken)
redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0
mem_req_valid  output  1  request to instruction memory
mem_req_ready  input  1  memory accepts the request this cycle
mem_req_addr  output  32  word-aligned fetch address
mem_rsp_valid  input  1  response word valid; responses return strictly in request order
mem_rsp_data  input  32  response instruction word
out_valid  output  1  FIFO head valid
out_ready  input  1  core consumes the head this cycle
out_instr  output  32  instruction at FIFO head
out_pc  output  32  PC of out_instr

Behaviour:
- Reset (rst=1 at an edge):
  - Clears the FIFO; out_valid=0.
  - Sets fetch_pc=RESET_PC and rsp_pc=RESET_PC.
  - Clears the inflight and stale counters.
  - mem_req_valid=0 while rst is high.
  - Reset mid-operation discards all buffered and in-flight data. Responses arriving after reset are NOT tracked; the memory must be reset together with this block.
- Request issue:
  - mem_req_valid = !rst && !redirect_valid && (count + inflight < DEPTH).
  - mem_req_addr = fetch_pc.
  - On a request handshake: fetch_pc += 4 (wraps modulo 2^32) and inflight increments.
- Response handling:
  - Each mem_rsp_valid decrements inflight.
  - If stale > 0: the response is dropped and stale decrements.
  - Otherwise: {mem_rsp_data, rsp_pc} is written to the FIFO tail and rsp_pc += 4.
  - Credit accounting guarantees the FIFO is never full when a response arrives; an overflow is a design error (assertion in the bench).
- Output:
  - out_valid = (count != 0); head data comes from registered storage.
  - Latency: a response at edge N is visible on the out_* ports in the cycle after edge N.
  - A pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_valid=1 at an edge):
  - The out handshake in that cycle still counts as consumed.
  - All remaining FIFO entries are flushed; count becomes 0.
  - stale = inflight after this cycle's request and response updates. No request issues in the redirect cycle, and a response arriving in the same cycle is dropped.
  - fetch_pc and rsp_pc are set to {redirect_pc[31:2],2'b00}.
  - Fetching resumes the next cycle while stale responses are still pending. Stale requests still occupy credits.
  - Back-to-back redirects: the last one wins; stale accumulates correctly.
- Held state: mem_req_valid and mem_req_addr remain stable until mem_req_ready (no retraction except on redirect or reset).
- Invariants: count + inflight <= DEPTH; stale <= inflight.
- Counter widths are clog2(DEPTH)+1.

Test Plan:
- Reset, then zero-latency memory (ready=1, response 1 cycle later), out_ready=1 -> mem_req_addr sequence 0,4,8,...; out_pc 0,4,8 with out_instr equal to memory contents; sustained 1 instr/cycle after the initial fill.
- out_ready=0 with DEPTH=4 -> exactly 4 requests issued, then mem_req_valid=0; out_valid held with out_pc=0; raising out_ready drains 0,4,8,12 in order, then fetching resumes at 16.
- 3-cycle response latency, redirect to 0x100 while 2 requests are in flight and 1 entry is buffered -> both old responses are dropped; first out_pc=0x100; no instruction from the old stream appears.
- Redirect with redirect_pc=0x103 in the same cycle as an out handshake and a mem_rsp_valid -> the head is consumed once; the response is dropped; next request and out_pc are 0x100.
- mem_req_ready held low for 5 cycles -> mem_req_addr stays stable and inflight does not change.
- RESET_PC=32'hFFFF_FFF8 -> request addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap); assert rst mid-stream -> out_valid=0 next cycle and fetch restarts at RESET_PC.
